// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address and runs the fetch handshake.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT, TRAP} state_t;

  state_t      state;
  state_t      state_next;
  logic        redirect;
  logic        misaligned;
  logic [31:0] raw_target;
  logic [31:0] target;

  // Jump outranks branch when both are asserted.
  always_comb begin
    redirect   = jump | branch_taken;
    raw_target = jump ? jump_target : branch_target;
`ifdef PC_MISALIGN_TRAP_EN
    target     = raw_target;
    misaligned = redirect && (raw_target[1:0] != 2'b00);
`else
    target     = raw_target & 32'hFFFF_FFFC;
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    state_next  = state;
    next_pc     = pc;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      BOOT: begin
        next_pc    = RESET_VECTOR;
        state_next = RUN;
      end
      RUN: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          state_next = WAIT;
        end else begin
          fetch_valid = 1'b1;
          if (stall) begin
            next_pc = pc;
          end else if (misaligned) begin
            next_pc    = pc;
            state_next = TRAP;
          end else if (redirect) begin
            next_pc = target;
          end else begin
            next_pc = pc + 32'd4;
          end
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = RUN;
      end
      TRAP: begin
        next_pc    = TRAP_VECTOR;
        state_next = RUN;
      end
      default: begin
        next_pc    = RESET_VECTOR;
        state_next = BOOT;
      end
    endcase
    // Reset overrides the outputs combinationally so they are safe before any edge.
    if (rst) begin
      next_pc     = RESET_VECTOR;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_count <= 32'd0;
    end else begin
      state <= state_next;
      if (fetch_valid && !stall) fetch_count <= fetch_count + 32'd1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // trap is high only in the TRAP cycle; trap_pc keeps the last offending target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap    <= 1'b0;
      trap_pc <= 32'd0;
    end else begin
      trap <= (state_next == TRAP) && (state == RUN);
      if ((state_next == TRAP) && (state == RUN)) trap_pc <= target;
    end
  end
`else
  assign trap    = 1'b0;
  assign trap_pc = 32'd0;
`endif

endmodule
